pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each cycle it decides which latches advance, which load a bubble, and where the PC comes from.
- Inputs: cache hits, load-use hazards, EX-resolved branches, ID-resolved jumps, halt reaching WB.
- Also keeps stall/flush performance counters; one instance sits in the datapath next to the forwarding unit.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_if.sv | 27 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: PC source select and counter width default.
package pipe_hazard_ctrl_pkg;
  localparam int HAZ_CNT_W = 32;

  typedef enum logic [1:0] {
    PC4    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2
  } pcsel_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the datapath and latch/PC controls back to it; master = datapath, slave = sequencer.
interface pipe_hazard_ctrl_if import pipe_hazard_ctrl_pkg::*; #(parameter int CNT_W = HAZ_CNT_W);
  logic             ihit, dhit, mem_dREN, mem_dWEN;
  logic             ex_dREN, ex_regWr, id_uses_rt, id_jump;
  logic             ex_branch, ex_bne, ex_equal, wb_halt;
  logic [4:0]       ex_regDst, id_rs, id_rt;
  logic             pc_en;
  pcsel_t           pc_sel;
  logic             ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_regDst,
           id_rs, id_rt, id_uses_rt, id_jump, ex_branch, ex_bne, ex_equal, wb_halt,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regWr, ex_regDst,
           id_rs, id_rt, id_uses_rt, id_jump, ex_branch, ex_bne, ex_equal, wb_halt,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(parameter int W = 32) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != {W{1'b1}}))
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencer: combinational enables/flushes/PC select from hazards and state;
// state, halt and stall/flush counters are registered.
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(parameter int CNT_W = HAZ_CNT_W) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} statetype_t;

  statetype_t r_state, w_next;
  logic       r_halt;
  logic       w_mem_req, w_taken, w_lu, w_go, w_retire;
  logic       w_stall_inc, w_flush_inc, w_pc_en;
  pcsel_t     w_pc_sel;
  logic [3:0] w_en;  // {ifid, idex, exmem, memwb}
  logic [2:0] w_fl;  // {ifid, idex, exmem}
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  assign w_mem_req = bus.mem_dREN | bus.mem_dWEN;
  assign w_taken   = bus.ex_branch & (bus.ex_equal ^ bus.ex_bne);
  assign w_lu      = bus.ex_dREN & bus.ex_regWr & (bus.ex_regDst != 5'd0) &
                     ((bus.ex_regDst == bus.id_rs) | (bus.id_uses_rt & (bus.ex_regDst == bus.id_rt)));

  always_comb begin
    w_en = '0; w_fl = '0; w_pc_en = 1'b0; w_pc_sel = PC4;
    w_stall_inc = 1'b0; w_flush_inc = 1'b0; w_go = 1'b0; w_retire = 1'b0;
    w_next = r_state;
    if (RST) begin
      w_en = 4'hF; w_fl = 3'h7; w_next = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_req && !bus.dhit) begin
            w_stall_inc = 1'b1; w_next = DWAIT;
          end else if (!bus.ihit) begin
            w_stall_inc = 1'b1; w_retire = w_mem_req;
          end else begin
            w_go = 1'b1;
          end
        end
        DWAIT: begin
          if (!bus.dhit) begin
            w_stall_inc = 1'b1;
          end else begin
            w_next = RUN;
            if (bus.ihit) w_go = 1'b1;
            else begin w_stall_inc = 1'b1; w_retire = 1'b1; end
          end
        end
        default: ;
      endcase
      // The finished access leaves MEM exactly once; EX/MEM takes a bubble so it is not replayed.
      if (w_retire) begin
        w_en = 4'b0011; w_fl = 3'b001;
      end
      if (w_go) begin
        w_en = 4'hF; w_pc_en = 1'b1;
        if (w_taken) begin
          w_pc_sel = BRANCH; w_fl = 3'b110; w_flush_inc = 1'b1;
        end else if (w_lu) begin
          w_pc_en = 1'b0; w_en[3] = 1'b0; w_fl = 3'b010; w_stall_inc = 1'b1;
        end else if (bus.id_jump) begin
          w_pc_sel = JUMP; w_fl = 3'b100; w_flush_inc = 1'b1;
        end
      end
      if (bus.wb_halt) w_next = HALTED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (bus.wb_halt) r_halt <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(CLK), .i_rst(RST), .i_inc(w_stall_inc), .o_cnt(w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk(CLK), .i_rst(RST), .i_inc(w_flush_inc), .o_cnt(w_flush_cnt)
  );

  assign bus.pc_en       = w_pc_en;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.ifid_en     = w_en[3];
  assign bus.idex_en     = w_en[2];
  assign bus.exmem_en    = w_en[1];
  assign bus.memwb_en    = w_en[0];
  assign bus.ifid_flush  = w_fl[2];
  assign bus.idex_flush  = w_fl[1];
  assign bus.exmem_flush = w_fl[0];
  assign bus.halt        = r_halt;
  assign bus.stall_cnt   = w_stall_cnt;
  assign bus.flush_cnt   = w_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (4-bit counters) with a per-cycle reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) b();
  pipe_hazard_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .bus(b));

  typedef struct packed {
    logic       pc_en;
    logic [1:0] sel;
    logic [3:0] en;
    logic [2:0] fl;
    logic       si;
    logic       fi;
    logic [1:0] nst;   // 0 running, 1 waiting on data, 2 halted
  } exp_t;

  int   n_vec = 0, n_err = 0;
  bit   m_ok = 0;
  int   m_st = 0, m_stall = 0, m_flush = 0;
  bit   m_halt = 0;

  // What the controls must be this cycle, read straight from the hazard rules.
  function automatic exp_t model();
    exp_t e;
    logic memreq, taken, lu, miss, go, retire;
    e = '0;
    e.nst = m_st[1:0];
    memreq = b.mem_dREN | b.mem_dWEN;
    taken  = b.ex_branch & (b.ex_equal ^ b.ex_bne);
    lu     = b.ex_dREN & b.ex_regWr & (b.ex_regDst != 0) &
             ((b.ex_regDst == b.id_rs) | (b.id_uses_rt & (b.ex_regDst == b.id_rt)));
    if (RST) begin
      e.en = 4'hF; e.fl = 3'h7; e.nst = 2'd0;
      return e;
    end
    if (m_st == 2) return e;
    miss   = (m_st == 1) ? !b.dhit : (memreq & !b.dhit);
    go     = !miss & b.ihit;
    retire = !miss & !b.ihit & ((m_st == 1) | memreq);
    if (go) begin
      e.en = 4'hF; e.pc_en = 1'b1;
      if (taken) begin e.sel = 2'd1; e.fl = 3'b110; e.fi = 1'b1; end
      else if (lu) begin e.pc_en = 1'b0; e.en = 4'b0111; e.fl = 3'b010; e.si = 1'b1; end
      else if (b.id_jump) begin e.sel = 2'd2; e.fl = 3'b100; e.fi = 1'b1; end
    end else begin
      e.si = 1'b1;
      if (retire) begin e.en = 4'b0011; e.fl = 3'b001; end
    end
    e.nst = miss ? 2'd1 : 2'd0;
    if (b.wb_halt) e.nst = 2'd2;
    return e;
  endfunction

  task automatic cmp();
    exp_t e;
    logic [CW-1:0] es, ef;
    if (!m_ok) return;
    e  = model();
    es = m_stall[CW-1:0];
    ef = m_flush[CW-1:0];
    n_vec++;
    if ({b.pc_en, b.pc_sel, b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en,
         b.ifid_flush, b.idex_flush, b.exmem_flush, b.halt, b.stall_cnt, b.flush_cnt} !==
        {e.pc_en, e.sel, e.en, e.fl, m_halt, es, ef}) begin
      n_err++;
      $display("FAIL model t=%0t got pc_en=%b sel=%0d en=%b fl=%b halt=%b stall=%0d flush=%0d want pc_en=%b sel=%0d en=%b fl=%b halt=%b stall=%0d flush=%0d",
               $time, b.pc_en, b.pc_sel, {b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en},
               {b.ifid_flush, b.idex_flush, b.exmem_flush}, b.halt, b.stall_cnt, b.flush_cnt,
               e.pc_en, e.sel, e.en, e.fl, m_halt, es, ef);
    end
  endtask

  task automatic upd();
    exp_t e;
    e = model();
    if (RST) begin
      m_st = 0; m_stall = 0; m_flush = 0; m_halt = 0; m_ok = 1;
    end else if (m_st != 2) begin
      if (e.si && m_stall < MAXC) m_stall++;
      if (e.fi && m_flush < MAXC) m_flush++;
      m_st = e.nst;
      if (b.wb_halt) m_halt = 1;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic neg();
    @(negedge CLK);
    cmp();
  endtask

  task automatic pos();
    @(posedge CLK);
    upd();
    #1;
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic idle();
    b.ihit = 1; b.dhit = 0; b.mem_dREN = 0; b.mem_dWEN = 0;
    b.ex_dREN = 0; b.ex_regWr = 0; b.ex_regDst = 0; b.id_rs = 0; b.id_rt = 0;
    b.id_uses_rt = 0; b.id_jump = 0; b.ex_branch = 0; b.ex_bne = 0; b.ex_equal = 0;
    b.wb_halt = 0;
  endtask

  task automatic set_lu();
    b.ex_dREN = 1; b.ex_regWr = 1; b.ex_regDst = 5'd8; b.id_rs = 5'd8;
  endtask

  initial begin
    idle();
    RST = 1;
    // Reset: bubbles everywhere, PC held, counters clear.
    neg();
    lit("rst_pc_en", b.pc_en, 0);
    lit("rst_flush", {b.ifid_flush, b.idex_flush, b.exmem_flush}, 3'h7);
    lit("rst_en", {b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en}, 4'hF);
    lit("rst_halt", b.halt, 0);
    lit("rst_cnt", {b.stall_cnt, b.flush_cnt}, 0);
    pos();
    tick();
    RST = 0;
    neg();
    lit("run_pc_en", b.pc_en, 1);
    lit("run_pc_sel", b.pc_sel, 0);
    pos();

    // Load-use on rs, then the same with r0 destination.
    set_lu();
    neg();
    lit("lu_pc_en", b.pc_en, 0);
    lit("lu_ifid_en", b.ifid_en, 0);
    lit("lu_idex_flush", b.idex_flush, 1);
    pos();
    lit("lu_stall_cnt", b.stall_cnt, 1);
    b.ex_regDst = 0; b.id_rs = 0;
    neg();
    lit("lu_r0_pc_en", b.pc_en, 1);
    pos();
    b.ex_regDst = 5'd9; b.id_rt = 5'd9; b.id_uses_rt = 1;
    tick();
    b.id_uses_rt = 0;
    tick();
    lit("lu_rt_stall_cnt", b.stall_cnt, 2);

    // Branch beats load-use and jump.
    idle(); set_lu();
    b.ex_branch = 1; b.ex_equal = 1; b.id_jump = 1;
    neg();
    lit("br_pc_sel", b.pc_sel, 1);
    lit("br_flush", {b.ifid_flush, b.idex_flush}, 2'b11);
    pos();
    lit("br_cnts", {b.flush_cnt, b.stall_cnt}, {4'd1, 4'd2});
    idle(); b.id_jump = 1;
    neg();
    lit("jmp_pc_sel", b.pc_sel, 2);
    lit("jmp_flush", {b.ifid_flush, b.idex_flush}, 2'b10);
    pos();
    idle(); b.ex_branch = 1; b.ex_bne = 1; b.ex_equal = 0;
    tick();
    b.ex_equal = 1;
    tick();
    lit("flush_cnt3", b.flush_cnt, 3);

    // Data miss: three waiting cycles, then the access retires without an ifetch.
    idle(); b.mem_dREN = 1;
    for (int i = 0; i < 3; i++) begin
      neg();
      lit("miss_en", {b.pc_en, b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en}, 0);
      pos();
    end
    lit("miss_stall", b.stall_cnt, 5);
    b.dhit = 1; b.ihit = 0;
    neg();
    lit("retire_en", {b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en}, 4'b0011);
    lit("retire_fl", {b.ifid_flush, b.idex_flush, b.exmem_flush}, 3'b001);
    pos();
    idle();
    neg();
    lit("after_miss_pc_en", b.pc_en, 1);
    pos();

    // Miss resolved together with ifetch, write hit without ifetch, plain imiss.
    b.mem_dREN = 1;
    tick();
    b.dhit = 1; b.id_jump = 1;
    tick();
    idle(); b.mem_dWEN = 1; b.dhit = 1; b.ihit = 0;
    tick();
    idle(); b.ihit = 0;
    tick();

    // Reset during a data wait returns to normal running.
    idle(); b.mem_dREN = 1;
    tick(); tick();
    RST = 1;
    tick();
    RST = 0; idle();
    neg();
    lit("rst_dwait_pc_en", b.pc_en, 1);
    pos();

    // Halt is sticky and freezes everything until reset.
    b.wb_halt = 1;
    tick();
    idle(); set_lu();
    neg();
    lit("halt_set", b.halt, 1);
    lit("halt_en", {b.pc_en, b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en}, 0);
    pos();
    for (int i = 0; i < 10; i++) tick();
    RST = 1;
    tick();
    RST = 0; idle();
    neg();
    lit("halt_clear", b.halt, 0);
    pos();

    // Saturation of both counters.
    set_lu();
    for (int i = 0; i < 20; i++) tick();
    lit("stall_sat", b.stall_cnt, 4'hF);
    idle(); b.id_jump = 1;
    for (int i = 0; i < 20; i++) tick();
    lit("flush_sat", b.flush_cnt, 4'hF);
    lit("stall_sat_hold", b.stall_cnt, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
